help_scroller: RTL

HELP_SCROLLER -- requirements
Module: help_scroller

---
 rtl/help_pkg.sv | 29 ++
 rtl/tick_gen.sv | 32 +++
 rtl/help_scroller.sv | 73 +++++++
 3 files changed

// File: rtl/help_pkg.sv
// help_pkg: letter codes and defaults shared by help_scroller and the
// downstream seven-segment decoder.
//   CODE_H/E/L/P : 4-bit letter codes shown on HEX3..HEX0
//   TICK_DIV_DEF : default clocks per scroll step (1 Hz at 50 MHz)
//   state_e      : scroller mode (PAUSE / RUN)
package help_pkg;

  localparam logic [3:0] CODE_H = 4'd0;
  localparam logic [3:0] CODE_E = 4'd1;
  localparam logic [3:0] CODE_L = 4'd2;
  localparam logic [3:0] CODE_P = 4'd3;

  localparam int TICK_DIV_DEF = 50000000;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Letter shown at display position pos (0 = leftmost) for rotation ofs.
  // Codes H,E,L,P are 0..3, so the rotated index is the code itself.
  function automatic logic [3:0] letter_at(input logic [1:0] ofs,
                                           input logic [1:0] pos);
    logic [1:0] s;
    s = ofs + pos;
    return {2'b00, s};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: scroll prescaler.
//   CLOCK_50 : clock
//   RESET    : synchronous active-high reset
//   EN       : count enable (scroller in RUN); counter held at 0 otherwise
//   TICK     : high in the cycle the counter sits at TICK_DIV-1 while enabled
module tick_gen #(
  parameter int TICK_DIV = help_pkg::TICK_DIV_DEF
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (EN && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/help_scroller.sv
// help_scroller: rotates "HELP" across four seven-segment displays.
//   CLOCK_50 : clock
//   RESET    : synchronous active-high reset (highest priority)
//   EN       : 1 = auto-scroll (RUN), 0 = hold (PAUSE)
//   DIR      : 0 = scroll left (offset +1), 1 = scroll right (offset -1)
//   STEP     : manual step request, rising edge honoured in PAUSE only
//   CODE3..0 : letter codes for HEX3 (leftmost) .. HEX0
//   ADV      : one-cycle pulse in the cycle the offset updates
module help_scroller
  import help_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       EN,
  input  logic       DIR,
  input  logic       STEP,
  output logic [3:0] CODE3,
  output logic [3:0] CODE2,
  output logic [3:0] CODE1,
  output logic [3:0] CODE0,
  output logic       ADV
);

  state_e     state_q;
  logic [1:0] ofs_q, ofs_d;
  logic       step_q;
  logic       adv_q;
  logic       tick;
  logic       step_rise;
  logic       adv;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .EN       (state_q == ST_RUN),
    .TICK     (tick)
  );

  // A step edge right after a timed advance (EN dropped on the terminal
  // count) is swallowed so ADV can never pulse on back-to-back cycles.
  assign step_rise = (state_q == ST_PAUSE) && STEP && !step_q && !adv_q;
  assign adv       = !RESET && (tick || step_rise);

  always_comb begin
    ofs_d = ofs_q;
    if (adv) ofs_d = DIR ? ofs_q - 2'd1 : ofs_q + 2'd1;
  end

  // Mode register follows EN every cycle; step history keeps tracking STEP
  // in RUN so an edge seen in RUN is never replayed after pausing.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_PAUSE;
      ofs_q   <= 2'd0;
      step_q  <= 1'b1;
      adv_q   <= 1'b0;
    end else begin
      state_q <= EN ? ST_RUN : ST_PAUSE;
      ofs_q   <= ofs_d;
      step_q  <= STEP;
      adv_q   <= adv;
    end
  end

  assign ADV   = adv;
  assign CODE3 = letter_at(ofs_q, 2'd0);
  assign CODE2 = letter_at(ofs_q, 2'd1);
  assign CODE1 = letter_at(ofs_q, 2'd2);
  assign CODE0 = letter_at(ofs_q, 2'd3);

endmodule
